// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with N-source operand forwarding, base ALU/compare
// datapath and an iterative radix-2 RV32M multiply/divide unit.
// Ports: clk/rst (sync, active high); ex_valid/ex_flush control; ex_pc, regfile
// operands, immediates and mux selects; ex_aluop/ex_cmpop; ex_md_en/ex_md_op for
// M-ops; ex_fwd_sel*/ex_fwd_data* forwarding; outputs ex_alu_out, ex_cmp_out
// (combinational) and ex_stall (combinational pipeline hold).

package ex_stage_md_pkg;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

endpackage

module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  FWD_SRCS = 2,
    localparam int unsigned FSW      = $clog2(FWD_SRCS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic                      ex_flush,
    input  logic [WIDTH-1:0]          ex_pc,
    input  logic [WIDTH-1:0]          ex_rs1_out,
    input  logic [WIDTH-1:0]          ex_rs2_out,
    input  logic [WIDTH-1:0]          ex_i_imm,
    input  logic [WIDTH-1:0]          ex_u_imm,
    input  logic [WIDTH-1:0]          ex_b_imm,
    input  logic [WIDTH-1:0]          ex_s_imm,
    input  logic [WIDTH-1:0]          ex_j_imm,
    input  logic                      ex_alumux1_sel,
    input  logic [2:0]                ex_alumux2_sel,
    input  logic                      ex_cmpmux_sel,
    input  alu_ops                    ex_aluop,
    input  branch_funct3_t            ex_cmpop,
    input  logic                      ex_md_en,
    input  logic [2:0]                ex_md_op,
    input  logic [FSW-1:0]            ex_fwd_sel1,
    input  logic [FSW-1:0]            ex_fwd_sel2,
    input  logic [FWD_SRCS*WIDTH-1:0] ex_fwd_data1,
    input  logic [FWD_SRCS*WIDTH-1:0] ex_fwd_data2,
    output logic [WIDTH-1:0]          ex_alu_out,
    output logic [WIDTH-1:0]          ex_cmp_out,
    output logic                      ex_stall
);

    localparam int unsigned CW  = $clog2(WIDTH + 1);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  acc_q, acc_d;       // product high half / partial remainder
    logic [WIDTH-1:0]  lo_q, lo_d;         // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0]  opb_q, opb_d;       // multiplicand / divisor magnitude
    logic              neg_q, neg_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  md_result_q, md_result_d;

    logic [WIDTH-1:0]  fwd_rs1, fwd_rs2, alu_a, alu_b, cmp_b, alu_res;
    logic              br_en;

    // Forwarding: out-of-range selects fall back to the regfile value
    always_comb begin
        fwd_rs1 = ex_rs1_out;
        fwd_rs2 = ex_rs2_out;
        for (int unsigned k = 1; k <= FWD_SRCS; k++) begin
            if (ex_fwd_sel1 == FSW'(k)) fwd_rs1 = ex_fwd_data1[(k-1)*WIDTH +: WIDTH];
            if (ex_fwd_sel2 == FSW'(k)) fwd_rs2 = ex_fwd_data2[(k-1)*WIDTH +: WIDTH];
        end
    end

    // Operand muxes
    always_comb begin
        alu_a = ex_alumux1_sel ? ex_pc : fwd_rs1;
        cmp_b = ex_cmpmux_sel ? ex_i_imm : fwd_rs2;
        case (ex_alumux2_sel)
            3'd0:    alu_b = ex_i_imm;
            3'd1:    alu_b = ex_u_imm;
            3'd2:    alu_b = ex_b_imm;
            3'd3:    alu_b = ex_s_imm;
            3'd4:    alu_b = fwd_rs2;
            3'd5:    alu_b = ex_j_imm;
            default: alu_b = '0;
        endcase
    end

    // Base ALU
    always_comb begin
        case (ex_aluop)
            alu_add: alu_res = alu_a + alu_b;
            alu_sll: alu_res = alu_a << alu_b[SHW-1:0];
            alu_sra: alu_res = WIDTH'($signed(alu_a) >>> alu_b[SHW-1:0]);
            alu_sub: alu_res = alu_a - alu_b;
            alu_xor: alu_res = alu_a ^ alu_b;
            alu_srl: alu_res = alu_a >> alu_b[SHW-1:0];
            alu_or:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    // Branch compare
    always_comb begin
        case (ex_cmpop)
            beq:     br_en = (fwd_rs1 == cmp_b);
            bne:     br_en = (fwd_rs1 != cmp_b);
            blt:     br_en = ($signed(fwd_rs1) < $signed(cmp_b));
            bge:     br_en = ($signed(fwd_rs1) >= $signed(cmp_b));
            bltu:    br_en = (fwd_rs1 < cmp_b);
            bgeu:    br_en = (fwd_rs1 >= cmp_b);
            default: br_en = 1'b0;
        endcase
    end

    assign ex_cmp_out = {{(WIDTH-1){1'b0}}, br_en};
    assign ex_alu_out = (state_q == DONE) ? md_result_q : alu_res;

    // M-unit issue decode: operand magnitudes, result sign and special cases
    logic             a_signed, b_signed, neg_a, neg_b, res_neg, is_rem;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, special_val;

    always_comb begin
        a_signed    = (ex_md_op == MD_MUL) || (ex_md_op == MD_MULH) || (ex_md_op == MD_MULHSU)
                   || (ex_md_op == MD_DIV) || (ex_md_op == MD_REM);
        b_signed    = (ex_md_op == MD_MUL) || (ex_md_op == MD_MULH)
                   || (ex_md_op == MD_DIV) || (ex_md_op == MD_REM);
        is_rem      = ex_md_op[2] & ex_md_op[1];
        neg_a       = a_signed & fwd_rs1[WIDTH-1];
        neg_b       = b_signed & fwd_rs2[WIDTH-1];
        abs_a       = neg_a ? -fwd_rs1 : fwd_rs1;
        abs_b       = neg_b ? -fwd_rs2 : fwd_rs2;
        res_neg     = is_rem ? neg_a : (neg_a ^ neg_b);
        div_zero    = ex_md_op[2] && (fwd_rs2 == '0);
        div_ovf     = ((ex_md_op == MD_DIV) || (ex_md_op == MD_REM))
                   && (fwd_rs1 == MIN_VAL) && (fwd_rs2 == '1);
        special_val = div_zero ? (is_rem ? fwd_rs1 : '1) : (is_rem ? '0 : MIN_VAL);
    end

    // One radix-2 iteration: shift-add multiply or restoring divide
    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_n, lo_n;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (op_q[2]) begin
            acc_n = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
            lo_n  = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            acc_n = mul_sum[WIDTH:1];
            lo_n  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod   = {acc_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        case (op_q)
            MD_MUL:                         final_res = prod_s[WIDTH-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   final_res = prod_s[2*WIDTH-1:WIDTH];
            MD_DIV, MD_DIVU:                final_res = neg_q ? -lo_n : lo_n;
            default:                        final_res = neg_q ? -acc_n : acc_n;
        endcase
    end

    // M-unit control: next state, datapath loads and stall
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        op_d        = op_q;
        md_result_d = md_result_q;
        ex_stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && ex_md_en && !ex_flush) begin
                    ex_stall = 1'b1;
                    op_d     = ex_md_op;
                    neg_d    = res_neg;
                    acc_d    = '0;
                    lo_d     = abs_a;
                    opb_d    = abs_b;
                    if (div_zero || div_ovf) begin
                        md_result_d = special_val;
                        count_d     = '0;
                        state_d     = DONE;
                    end else begin
                        count_d = CW'(WIDTH);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                ex_stall = 1'b1;
                acc_d    = acc_n;
                lo_d     = lo_n;
                count_d  = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    md_result_d = final_res;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A flush abandons any M-op without touching the last result
        if (ex_flush) begin
            state_d     = IDLE;
            count_d     = '0;
            md_result_d = md_result_q;
            ex_stall    = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            op_q        <= '0;
            md_result_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            md_result_q <= md_result_d;
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: self-checking bench for ex_stage_md with directed and
// randomized stimulus against a behavioural reference model.
module tb_ex_stage_md;
    import ex_stage_md_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ex_valid, ex_flush;
    logic [31:0]          ex_pc, ex_rs1_out, ex_rs2_out;
    logic [31:0]          ex_i_imm, ex_u_imm, ex_b_imm, ex_s_imm, ex_j_imm;
    logic                 ex_alumux1_sel;
    logic [2:0]           ex_alumux2_sel;
    logic                 ex_cmpmux_sel;
    alu_ops               ex_aluop;
    branch_funct3_t       ex_cmpop;
    logic                 ex_md_en;
    logic [2:0]           ex_md_op;
    logic [1:0]           ex_fwd_sel1, ex_fwd_sel2;
    logic [63:0]          ex_fwd_data1, ex_fwd_data2;
    logic [31:0]          ex_alu_out, ex_cmp_out;
    logic                 ex_stall;

    int n_checks = 0;
    int n_fail   = 0;

    branch_funct3_t cmp_tbl [6] = '{beq, bne, blt, bge, bltu, bgeu};

    ex_stage_md dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_pc(ex_pc),
        .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out),
        .ex_i_imm(ex_i_imm), .ex_u_imm(ex_u_imm), .ex_b_imm(ex_b_imm),
        .ex_s_imm(ex_s_imm), .ex_j_imm(ex_j_imm),
        .ex_alumux1_sel(ex_alumux1_sel), .ex_alumux2_sel(ex_alumux2_sel),
        .ex_cmpmux_sel(ex_cmpmux_sel), .ex_aluop(ex_aluop), .ex_cmpop(ex_cmpop),
        .ex_md_en(ex_md_en), .ex_md_op(ex_md_op),
        .ex_fwd_sel1(ex_fwd_sel1), .ex_fwd_sel2(ex_fwd_sel2),
        .ex_fwd_data1(ex_fwd_data1), .ex_fwd_data2(ex_fwd_data2),
        .ex_alu_out(ex_alu_out), .ex_cmp_out(ex_cmp_out), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_pick(logic [1:0] sel, logic [31:0] rs, logic [63:0] data);
        if (sel == 2'd1) return data[31:0];
        if (sel == 2'd2) return data[63:32];
        return rs;
    endfunction

    function automatic logic [31:0] alu_ref(alu_ops op, logic [31:0] a, logic [31:0] b);
        case (op)
            alu_add: return a + b;
            alu_sll: return a << b[4:0];
            alu_sra: return 32'($signed(a) >>> b[4:0]);
            alu_sub: return a - b;
            alu_xor: return a ^ b;
            alu_srl: return a >> b[4:0];
            alu_or:  return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic cmp_ref(branch_funct3_t op, logic [31:0] a, logic [31:0] b);
        case (op)
            beq:     return a == b;
            bne:     return a != b;
            blt:     return $signed(a) < $signed(b);
            bge:     return $signed(a) >= $signed(b);
            bltu:    return a < b;
            bgeu:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // RV32M semantics computed with 64-bit arithmetic
    function automatic logic [31:0] md_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_flush = 0; ex_pc = 0; ex_rs1_out = 0; ex_rs2_out = 0;
        ex_i_imm = 0; ex_u_imm = 0; ex_b_imm = 0; ex_s_imm = 0; ex_j_imm = 0;
        ex_alumux1_sel = 0; ex_alumux2_sel = 0; ex_cmpmux_sel = 0;
        ex_aluop = alu_add; ex_cmpop = beq; ex_md_en = 0; ex_md_op = 0;
        ex_fwd_sel1 = 0; ex_fwd_sel2 = 0; ex_fwd_data1 = 0; ex_fwd_data2 = 0;
    endtask

    // Issue one M-op, measure stall length, check result and its single-cycle visibility
    task automatic run_md(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [1:0] s1, input logic [1:0] s2,
                          input logic [63:0] d1, input logic [63:0] d2);
        logic [31:0] ea, eb, exp;
        int          stalls, exp_stalls;
        logic        done;
        ea  = fwd_pick(s1, rs1, d1);
        eb  = fwd_pick(s2, rs2, d2);
        exp = md_ref(op, ea, eb);
        exp_stalls = (op[2] && (eb == 0 || ((op == 3'd4 || op == 3'd6) &&
                      ea == 32'h8000_0000 && eb == 32'hFFFF_FFFF))) ? 1 : 33;
        @(posedge clk); #1;
        ex_valid = 1; ex_md_en = 1; ex_md_op = op; ex_rs1_out = rs1; ex_rs2_out = rs2;
        ex_fwd_sel1 = s1; ex_fwd_sel2 = s2; ex_fwd_data1 = d1; ex_fwd_data2 = d2;
        ex_alumux1_sel = 0; ex_alumux2_sel = 0; ex_i_imm = 0; ex_aluop = alu_add;
        stalls = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ex_stall) stalls++;
            else done = 1;
        end
        check_eq($sformatf("md_done op%0d", op), 32'(done), 32'd1);
        check_eq($sformatf("md_stalls op%0d", op), 32'(stalls), 32'(exp_stalls));
        check_eq($sformatf("md_result op%0d %h,%h", op, ea, eb), ex_alu_out, exp);
        @(posedge clk); #1;
        ex_valid = 0; ex_md_en = 0;
        @(negedge clk);
        check_eq("md_one_cycle", ex_alu_out, ea);
        check_eq("md_after_stall", 32'(ex_stall), 32'd0);
    endtask

    initial begin
        logic [31:0] ea, eb, m2, cb;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          r;

        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(ex_stall), 32'd0);
        check_eq("rst_alu", ex_alu_out, 32'd0);
        check_eq("rst_cmp", ex_cmp_out, 32'd1);
        @(posedge clk); #1; rst = 0;

        // Forwarding into ADD
        ex_valid = 1; ex_rs1_out = 32'h5; ex_i_imm = 32'h3; ex_fwd_sel1 = 2'd1;
        ex_fwd_data1 = {32'hDEAD_0000, 32'h10};
        @(negedge clk);
        check_eq("fwd_mem_add", ex_alu_out, 32'h13);
        check_eq("fwd_mem_stall", 32'(ex_stall), 32'd0);
        #1 ex_fwd_sel1 = 2'd3;
        #1 check_eq("fwd_oor_add", ex_alu_out, 32'h8);
        ex_fwd_sel1 = 2'd2;
        #1 check_eq("fwd_wb_add", ex_alu_out, 32'hDEAD_0003);

        // md_en without valid must not start
        @(posedge clk); #1; ex_valid = 0; ex_md_en = 1; ex_md_op = 3'd0;
        @(negedge clk); check_eq("noval_stall", 32'(ex_stall), 32'd0);
        @(posedge clk); #1; idle_inputs();

        // Directed M-ops
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_md(3'd4, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0);
        run_md(3'd6, 32'hFFFF_FFF9, 32'h2, 0, 0, 0, 0);
        run_md(3'd5, 32'h1234, 32'h0, 0, 0, 0, 0);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        run_md(3'd7, 32'h55, 32'h0, 0, 0, 0, 0);

        // Flush mid-BUSY when 10 iterations remain
        @(posedge clk); #1;
        ex_valid = 1; ex_md_en = 1; ex_md_op = 3'd0; ex_rs1_out = 7; ex_rs2_out = 9;
        repeat (23) @(posedge clk);
        #1 ex_flush = 1;
        @(negedge clk); check_eq("flush_stall", 32'(ex_stall), 32'd0);
        @(posedge clk); #1; ex_flush = 0; ex_valid = 0; ex_md_en = 0;
        @(negedge clk); check_eq("post_flush_idle", 32'(ex_stall), 32'd0);
        run_md(3'd0, 32'd3, 32'd4, 0, 0, 0, 0);

        // Synchronous reset mid-BUSY
        @(posedge clk); #1;
        ex_valid = 1; ex_md_en = 1; ex_md_op = 3'd4; ex_rs1_out = 100; ex_rs2_out = 7;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1; rst = 0; ex_valid = 0; ex_md_en = 0;
        @(negedge clk); check_eq("rst_mid_busy", 32'(ex_stall), 32'd0);

        // BEQ with rs2 forwarded from WB
        ex_rs1_out = 32'hCAFE_F00D; ex_rs2_out = 32'h1; ex_cmpop = beq;
        ex_fwd_sel2 = 2'd2; ex_fwd_data2 = {32'hCAFE_F00D, 32'h2};
        #1 check_eq("beq_fwd_wb", ex_cmp_out, 32'h1);
        ex_fwd_sel2 = 2'd1;
        #1 check_eq("beq_fwd_mem", ex_cmp_out, 32'h0);

        // Random ALU / compare traffic
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            ex_valid = 1'($urandom); ex_md_en = 0; ex_pc = $urandom;
            ex_rs1_out = $urandom; ex_rs2_out = $urandom;
            ex_i_imm = $urandom; ex_u_imm = $urandom; ex_b_imm = $urandom;
            ex_s_imm = $urandom; ex_j_imm = $urandom;
            ex_alumux1_sel = 1'($urandom); ex_alumux2_sel = 3'($urandom);
            ex_cmpmux_sel = 1'($urandom);
            ex_aluop = alu_ops'(3'($urandom));
            ex_cmpop = cmp_tbl[$urandom_range(0, 5)];
            ex_fwd_sel1 = 2'($urandom); ex_fwd_sel2 = 2'($urandom);
            ex_fwd_data1 = {$urandom, $urandom}; ex_fwd_data2 = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) ex_fwd_data2[31:0] = fwd_pick(ex_fwd_sel1, ex_rs1_out, ex_fwd_data1);
            ea = fwd_pick(ex_fwd_sel1, ex_rs1_out, ex_fwd_data1);
            eb = fwd_pick(ex_fwd_sel2, ex_rs2_out, ex_fwd_data2);
            case (ex_alumux2_sel)
                3'd0: m2 = ex_i_imm;  3'd1: m2 = ex_u_imm;  3'd2: m2 = ex_b_imm;
                3'd3: m2 = ex_s_imm;  3'd4: m2 = eb;        3'd5: m2 = ex_j_imm;
                default: m2 = 32'd0;
            endcase
            cb = ex_cmpmux_sel ? ex_i_imm : eb;
            @(negedge clk);
            check_eq($sformatf("rnd_alu %0d", i), ex_alu_out,
                     alu_ref(ex_aluop, ex_alumux1_sel ? ex_pc : ea, m2));
            check_eq($sformatf("rnd_cmp %0d", i), ex_cmp_out, {31'd0, cmp_ref(ex_cmpop, ea, cb)});
            check_eq($sformatf("rnd_stall %0d", i), 32'(ex_stall), 32'd0);
        end
        @(posedge clk); #1; idle_inputs();

        // Random M-ops including corner operands and forwarded sources
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom);
            a  = $urandom; b = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0) b = 0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = $urandom_range(1, 15);
            run_md(op, a, b, 2'($urandom), 2'($urandom),
                   {a, $urandom}, {$urandom, b});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
